pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register, the generalised successor to the fixed-field inter-stage registers in the pipeline. It carries an opaque DW-bit payload plus a valid bit from one stage to the next. It honours the global stall vector at a configurable stage index and supports an explicit flush. It also keeps saturating bubble/hold counters for performance analysis. One instance sits between each pair of adjacent stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg.sv | 101 ++++++++++
 tb/tb_pipe_stage_reg.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic inter-stage pipeline register. Carries an opaque DW-bit payload
//   and a valid bit from one stage to the next, honouring the global stall
//   vector at bit STAGE (upstream) and STAGE+1 (downstream), with an explicit
//   flush. Two saturating counters record stall bubbles and hold cycles.
//
// Ports
//   Clk        in   rising-edge clock
//   Rst_n      in   asynchronous active-low reset
//   stall      in   [STALL_W] global stall vector, 1 = stop
//   flush      in   discard stage contents this cycle
//   clr_cnt    in   synchronous clear of both counters
//   in_data    in   [DW] payload from upstream
//   in_valid   in   upstream payload is a real instruction
//   out_data   out  [DW] registered payload
//   out_valid  out  registered valid
//   out_load   out  one-cycle strobe after a load that captured in_valid=1
//   bubble_cnt out  [CNT_W] bubbles inserted by stall (saturating)
//   hold_cnt   out  [CNT_W] cycles contents were held (saturating)

module pipe_stage_reg #(
    parameter int              DW      = 32,
    parameter int              STALL_W = 6,
    parameter int              STAGE   = 2,
    parameter logic [DW-1:0]   NOP_VAL = {DW{1'b0}},
    parameter int              CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               clr_cnt,
    input  logic [DW-1:0]      in_data,
    input  logic               in_valid,
    output logic [DW-1:0]      out_data,
    output logic               out_valid,
    output logic               out_load,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt
);

    if (STAGE < 0 || STAGE + 1 >= STALL_W) begin : g_bad_stage
        $error("pipe_stage_reg: STAGE+1 must be below STALL_W");
    end

    if (DW < 1 || DW > 256) begin : g_bad_dw
        $error("pipe_stage_reg: DW must be in 1..256");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic su;
    logic sd;
    logic do_bubble;
    logic do_hold;

    assign su = stall[STAGE];
    assign sd = stall[STAGE+1];

    // Flush outranks both stall outcomes, so neither counter moves on a flush.
    assign do_bubble = !flush && su && !sd;
    assign do_hold   = !flush && su && sd;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_data  <= NOP_VAL;
            out_valid <= 1'b0;
            out_load  <= 1'b0;
        end else if (flush || do_bubble) begin
            out_data  <= NOP_VAL;
            out_valid <= 1'b0;
            out_load  <= 1'b0;
        end else if (!su) begin
            // su=0 loads regardless of sd; su=0/sd=1 is not a legal stall
            // pattern and is deliberately folded into the load case.
            out_data  <= in_data;
            out_valid <= in_valid;
            out_load  <= in_valid;
        end else begin
            out_load  <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
        end else if (clr_cnt) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
        end else begin
            if (do_bubble && bubble_cnt != CNT_MAX) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
            if (do_hold && hold_cnt != CNT_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Directed bench for pipe_stage_reg. Three instances share clock, reset,
//   flush, clr_cnt and payload inputs:
//     u0  DW=32, STAGE=2, CNT_W=16, NOP_VAL=0x13   (main behaviour)
//     u1  DW=32, STAGE=2, CNT_W=2                  (counter saturation)
//     u2  DW=8,  STAGE=4, own stall vector         (parameter sweep)

module tb_pipe_stage_reg;

    localparam logic [31:0] NOP0 = 32'h0000_0013;
    localparam logic [7:0]  NOP2 = 8'h5A;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [5:0]  stall;
    logic [5:0]  stall2;
    logic        flush;
    logic        clr_cnt;
    logic [31:0] in_data;
    logic        in_valid;

    logic [31:0] out_data0;
    logic        out_valid0;
    logic        out_load0;
    logic [15:0] bubble_cnt0;
    logic [15:0] hold_cnt0;

    logic [31:0] out_data1;
    logic        out_valid1;
    logic        out_load1;
    logic [1:0]  bubble_cnt1;
    logic [1:0]  hold_cnt1;

    logic [7:0]  out_data2;
    logic        out_valid2;
    logic        out_load2;
    logic [15:0] bubble_cnt2;
    logic [15:0] hold_cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    pipe_stage_reg #(.DW(32), .STALL_W(6), .STAGE(2), .NOP_VAL(NOP0), .CNT_W(16)) u0 (
        .Clk(Clk), .Rst_n(Rst_n), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data0), .out_valid(out_valid0), .out_load(out_load0),
        .bubble_cnt(bubble_cnt0), .hold_cnt(hold_cnt0)
    );

    pipe_stage_reg #(.DW(32), .STALL_W(6), .STAGE(2), .CNT_W(2)) u1 (
        .Clk(Clk), .Rst_n(Rst_n), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data1), .out_valid(out_valid1), .out_load(out_load1),
        .bubble_cnt(bubble_cnt1), .hold_cnt(hold_cnt1)
    );

    pipe_stage_reg #(.DW(8), .STALL_W(6), .STAGE(4), .NOP_VAL(NOP2), .CNT_W(16)) u2 (
        .Clk(Clk), .Rst_n(Rst_n), .stall(stall2), .flush(flush), .clr_cnt(clr_cnt),
        .in_data(in_data[7:0]), .in_valid(in_valid),
        .out_data(out_data2), .out_valid(out_valid2), .out_load(out_load2),
        .bubble_cnt(bubble_cnt2), .hold_cnt(hold_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge; inputs are changed and
    // outputs sampled here, well away from the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst_n    = 1'b0;
        stall    = '0;
        stall2   = '0;
        flush    = 1'b0;
        clr_cnt  = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_data",   out_data0,   NOP0);
        check("rst_valid",  out_valid0,  0);
        check("rst_load",   out_load0,   0);
        check("rst_bubble", bubble_cnt0, 0);
        check("rst_hold",   hold_cnt0,   0);
        check("rst_data_u2", out_data2,  NOP2);

        // Release: nothing moves before the edge
        Rst_n = 1'b1;
        #2;
        check("rel_no_edge_data", out_data0, NOP0);
        in_data  = 32'hDEADBEEF;
        in_valid = 1'b1;
        tick();
        check("load1_data",  out_data0,  32'hDEADBEEF);
        check("load1_valid", out_valid0, 1);
        check("load1_load",  out_load0,  1);

        // Load of a non-instruction
        in_data  = 32'h1111_1111;
        in_valid = 1'b0;
        tick();
        check("load_inv_data",  out_data0,  32'h1111_1111);
        check("load_inv_valid", out_valid0, 0);
        check("load_inv_load",  out_load0,  0);

        // Hold for 5 cycles
        in_data  = 32'h1234_5678;
        in_valid = 1'b1;
        tick();
        stall   = 6'b001100;
        in_data = 32'hFFFF_0000;
        tick();
        check("hold_first_load", out_load0, 0);
        tick();
        tick();
        tick();
        tick();
        check("hold_data",   out_data0,   32'h1234_5678);
        check("hold_valid",  out_valid0,  1);
        check("hold_load",   out_load0,   0);
        check("hold_cnt5",   hold_cnt0,   5);
        check("hold_bubble", bubble_cnt0, 0);

        // Asynchronous reset mid-hold, no edge needed
        Rst_n = 1'b0;
        #1;
        check("async_data",  out_data0,  NOP0);
        check("async_valid", out_valid0, 0);
        check("async_hold",  hold_cnt0,  0);
        tick();
        Rst_n    = 1'b1;
        stall    = '0;
        in_data  = 32'h0;
        in_valid = 1'b0;
        tick();
        check("post_rst_empty", out_valid0, 0);

        // Bubble for 3 cycles
        stall    = 6'b000100;
        in_data  = 32'h7777_7777;
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        check("bub_valid",  out_valid0,  0);
        check("bub_data",   out_data0,   NOP0);
        check("bub_cnt3",   bubble_cnt0, 3);
        check("bub_hold",   hold_cnt0,   0);

        // su=0, sd=1 behaves as load
        stall    = 6'b001000;
        in_data  = 32'hCAFE_F00D;
        in_valid = 1'b1;
        tick();
        check("illegal_data",   out_data0,   32'hCAFE_F00D);
        check("illegal_load",   out_load0,   1);
        check("illegal_bubble", bubble_cnt0, 3);
        check("illegal_hold",   hold_cnt0,   0);

        // Flush outranks hold and bubble
        stall   = '0;
        in_data = 32'hA5A5_A5A5;
        tick();
        flush   = 1'b1;
        stall   = 6'b001100;
        tick();
        check("flush_valid",  out_valid0,  0);
        check("flush_data",   out_data0,   NOP0);
        check("flush_load",   out_load0,   0);
        check("flush_hold",   hold_cnt0,   0);
        check("flush_bubble", bubble_cnt0, 3);
        stall = 6'b000100;
        tick();
        check("flush_bub_cnt", bubble_cnt0, 3);
        flush = 1'b0;

        // Clear wins over a simultaneous hold increment
        clr_cnt = 1'b1;
        stall   = 6'b001100;
        tick();
        clr_cnt = 1'b0;
        check("clr_hold",   hold_cnt0,   0);
        check("clr_bubble", bubble_cnt0, 0);

        // Saturation on CNT_W=2
        stall = 6'b000100;
        repeat (5) tick();
        check("sat_bub_u1", bubble_cnt1, 3);
        check("nosat_bub_u0", bubble_cnt0, 5);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_bub_u1", bubble_cnt1, 0);
        check("clr_bub_u0", bubble_cnt0, 0);
        stall = 6'b001100;
        repeat (4) tick();
        check("sat_hold_u1", hold_cnt1, 3);
        check("nosat_hold_u0", hold_cnt0, 4);

        // Parameter sweep: u2 governed by stall[4]/stall[5] only
        stall   = '0;
        clr_cnt = 1'b1;
        tick();
        clr_cnt  = 1'b0;
        stall2   = 6'b001100;
        in_data  = 32'h0000_0077;
        in_valid = 1'b1;
        tick();
        check("sw_low_bits_data", out_data2,   8'h77);
        check("sw_low_bits_load", out_load2,   1);
        check("sw_low_bits_hold", hold_cnt2,   0);
        check("sw_low_bits_bub",  bubble_cnt2, 0);
        stall2 = 6'b010000;
        tick();
        check("sw_bub_valid", out_valid2,  0);
        check("sw_bub_data",  out_data2,   NOP2);
        check("sw_bub_cnt",   bubble_cnt2, 1);
        stall2  = '0;
        in_data = 32'h0000_0099;
        tick();
        stall2  = 6'b110000;
        in_data = 32'h0000_0011;
        tick();
        tick();
        check("sw_hold_data", out_data2, 8'h99);
        check("sw_hold_cnt",  hold_cnt2, 2);
        stall2  = 6'b100000;
        in_data = 32'h0000_0042;
        tick();
        check("sw_illegal_data", out_data2, 8'h42);
        check("sw_u0_loaded",    out_data0, 32'h0000_0042);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
